// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Time word layout is {min_tens, min_units, sec_tens, sec_units}, one nibble each.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    localparam int DIGIT_W       = 4;
    localparam int SEC_UNITS_LSB = 0;
    localparam int SEC_TENS_LSB  = 4;
    localparam int MIN_UNITS_LSB = 8;
    localparam int MIN_TENS_LSB  = 12;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Command/status bundle between the timer and its controller.
interface bcd_countdown_timer_if;
    logic        i_CE;
    logic        i_Load;
    logic        i_Start;
    logic        i_Stop;
    logic [15:0] i_Preset;
    logic [15:0] o_Time;
    logic        o_Running;
    logic        o_Done;

    modport master (
        output i_CE, i_Load, i_Start, i_Stop, i_Preset,
        input  o_Time, o_Running, o_Done
    );

    modport slave (
        input  i_CE, i_Load, i_Start, i_Stop, i_Preset,
        output o_Time, o_Running, o_Done
    );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit that wraps 0 -> MAX and borrows from the next digit up.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);
    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (dec_i && borrow_i) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign borrow_o = dec_i && borrow_i && (digit_q == 4'd0);
endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: preset register and control FSM around four BCD digits,
// advanced by the prescaler clock-enable while running.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter bit          AUTO_RELOAD  = 1'b0,
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input logic                 i_CLK,
    input logic                 i_Reset,
    bcd_countdown_timer_if.slave tmr
);
    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    state_t      state_q;
    logic [15:0] preset_q;
    logic        running_q;
    logic        done_q;

    logic [15:0] preset_clamped;
    logic [15:0] load_val;
    logic [15:0] time_w;
    logic [4:0]  borrow;
    logic        digit_load;
    logic        dec;
    logic        time_zero;
    logic        reach_zero;
    logic        underflow;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 3) ? MT_MAX :
                                         (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;

            assign preset_clamped[gi*DIGIT_W +: DIGIT_W] =
                clamp_digit(tmr.i_Preset[gi*DIGIT_W +: DIGIT_W], LIM);

            bcd_digit_down #(.MAX(LIM)) u_digit (
                .clk_i      (i_CLK),
                .rst_n_i    (i_Reset),
                .load_i     (digit_load),
                .load_val_i (load_val[gi*DIGIT_W +: DIGIT_W]),
                .dec_i      (dec),
                .borrow_i   (borrow[gi]),
                .digit_o    (time_w[gi*DIGIT_W +: DIGIT_W]),
                .borrow_o   (borrow[gi+1])
            );
        end
    endgenerate

    assign time_zero  = (time_w == 16'h0000);
    assign reach_zero = dec && (time_w == 16'h0001);
    // A borrow out of min_tens cannot occur because 00:00 is never decremented;
    // it is folded into the zero-reached path so a corrupted count still terminates.
    assign underflow  = borrow[4];

    // Digit load/decrement control. In RUN a zero count only exists for the
    // single auto-reload cycle, which reloads the preset regardless of i_CE.
    always_comb begin
        digit_load = 1'b0;
        load_val   = preset_clamped;
        dec        = 1'b0;
        if (tmr.i_Load) begin
            digit_load = 1'b1;
        end else if (state_q == ST_RUN && !tmr.i_Stop) begin
            if (time_zero) begin
                digit_load = 1'b1;
                load_val   = preset_q;
            end else begin
                dec = tmr.i_CE;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q   <= ST_IDLE;
            preset_q  <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tmr.i_Load) begin
                preset_q  <= preset_clamped;
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!tmr.i_Stop && tmr.i_Start && !time_zero) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (tmr.i_Stop) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (reach_zero || underflow) begin
                            done_q <= 1'b1;
                            if (!(AUTO_RELOAD && preset_q != 16'h0000)) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!tmr.i_Stop && tmr.i_Start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                    end
                endcase
            end
        end
    end

    assign tmr.o_Time    = time_w;
    assign tmr.o_Running = running_q;
    assign tmr.o_Done    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: two timers (no reload / auto-reload with min_tens limit 5) share
// one stimulus stream; a seconds-based reference model predicts each cycle's outputs.
module tb_bcd_countdown_timer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_countdown_timer_if bus0();
    bcd_countdown_timer_if bus1();

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0), .MIN_TENS_MAX(9)) dut0 (
        .i_CLK(clk), .i_Reset(rst_n), .tmr(bus0));
    bcd_countdown_timer #(.AUTO_RELOAD(1'b1), .MIN_TENS_MAX(5)) dut1 (
        .i_CLK(clk), .i_Reset(rst_n), .tmr(bus1));

    typedef struct {
        logic [15:0] t;
        bit          run;
        bit          done;
        string       tag;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode[2];
    int m_secs[2];
    int m_preset[2];
    bit m_done[2];
    int tens_max[2] = '{9, 5};
    bit auto_rl[2]  = '{1'b0, 1'b1};

    int    vectors    = 0;
    int    miscompares = 0;
    string phase      = "reset";

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic int preset_secs(input logic [15:0] p, input int k);
        int mt, mu, st, su;
        mt = int'(p[15:12]); mu = int'(p[11:8]); st = int'(p[7:4]); su = int'(p[3:0]);
        if (mt > tens_max[k]) mt = tens_max[k];
        if (mu > 9) mu = 9;
        if (st > 5) st = 5;
        if (su > 9) su = 9;
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic void model_step(input int k, input bit ce, input bit ld,
                                       input bit st, input bit sp, input logic [15:0] p);
        m_done[k] = 1'b0;
        if (!rst_n) begin
            m_mode[k] = M_IDLE; m_secs[k] = 0; m_preset[k] = 0;
        end else if (ld) begin
            m_preset[k] = preset_secs(p, k);
            m_secs[k]   = m_preset[k];
            m_mode[k]   = M_IDLE;
        end else begin
            case (m_mode[k])
                M_IDLE:  if (!sp && st && m_secs[k] != 0) m_mode[k] = M_RUN;
                M_RUN: begin
                    if (sp) m_mode[k] = M_PAUSE;
                    else if (m_secs[k] == 0) m_secs[k] = m_preset[k];
                    else if (ce) begin
                        m_secs[k] = m_secs[k] - 1;
                        if (m_secs[k] == 0) begin
                            m_done[k] = 1'b1;
                            if (!(auto_rl[k] && m_preset[k] != 0)) m_mode[k] = M_DONE;
                        end
                    end
                end
                M_PAUSE: if (!sp && st) m_mode[k] = M_RUN;
                default: ;
            endcase
        end
    endfunction

    function automatic exp_t make_exp(input int k);
        exp_t e;
        e.t    = to_bcd(m_secs[k]);
        e.run  = (m_mode[k] == M_RUN);
        e.done = m_done[k];
        e.tag  = phase;
        return e;
    endfunction

    task automatic compare(input int k, input logic [15:0] t, input logic r,
                           input logic d, input exp_t e);
        vectors++;
        if (t !== e.t || r !== e.run || d !== e.done) begin
            miscompares++;
            $display("FAIL %s dut%0d: got time=%h run=%b done=%b, required time=%h run=%b done=%b",
                     e.tag, k, t, r, d, e.t, e.run, e.done);
        end
    endtask

    task automatic drive(input bit ce, input bit ld, input bit st, input bit sp,
                         input logic [15:0] p);
        bus0.i_CE = ce; bus0.i_Load = ld; bus0.i_Start = st; bus0.i_Stop = sp; bus0.i_Preset = p;
        bus1.i_CE = ce; bus1.i_Load = ld; bus1.i_Start = st; bus1.i_Stop = sp; bus1.i_Preset = p;
    endtask

    task automatic apply(input bit ce, input bit ld, input bit st, input bit sp,
                         input logic [15:0] p);
        drive(ce, ld, st, sp, p);
        model_step(0, ce, ld, st, sp, p);
        model_step(1, ce, ld, st, sp, p);
        exp_q0.push_back(make_exp(0));
        exp_q1.push_back(make_exp(1));
        $display("cycle %s: ce=%b load=%b start=%b stop=%b preset=%h -> exp0=%h exp1=%h",
                 phase, ce, ld, st, sp, p, to_bcd(m_secs[0]), to_bcd(m_secs[1]));
    endtask

    task automatic cyc(input bit ce, input bit ld, input bit st, input bit sp,
                       input logic [15:0] p);
        @(negedge clk);
        apply(ce, ld, st, sp, p);
    endtask

    task automatic mid_reset();
        exp_t z;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b0;
        #1;
        z.t = 16'h0000; z.run = 1'b0; z.done = 1'b0; z.tag = "reset_immediate";
        compare(0, bus0.o_Time, bus0.o_Running, bus0.o_Done, z);
        compare(1, bus1.o_Time, bus1.o_Running, bus1.o_Done, z);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                compare(0, bus0.o_Time, bus0.o_Running, bus0.o_Done, e);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                compare(1, bus1.o_Time, bus1.o_Running, bus1.o_Done, e);
            end
        end
    end

    initial begin
        bit ce, ld, st, sp;
        logic [15:0] p;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        release_rst();

        phase = "borrow_0103";
        cyc(0, 1, 0, 0, 16'h0103);
        cyc(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 4; i++) begin cyc(1, 0, 0, 0, 16'h0); cyc(0, 0, 0, 0, 16'h0); end

        phase = "reset_mid_run";
        cyc(0, 1, 0, 0, 16'h0130);
        cyc(0, 0, 1, 0, 16'h0);
        mid_reset();
        cyc(1, 0, 0, 0, 16'h0);
        release_rst();
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 0, 1, 0, 16'h0);

        phase = "reach_zero";
        cyc(0, 1, 0, 0, 16'h0002);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);

        phase = "pause";
        cyc(0, 1, 0, 0, 16'h0010);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 1, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);

        phase = "zero_preset";
        cyc(0, 1, 0, 0, 16'h0000);
        cyc(1, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);

        phase = "clamp";
        cyc(0, 1, 0, 0, 16'hAF7C);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(1, 1, 1, 0, 16'h0203);
        cyc(1, 0, 0, 0, 16'h0);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                mid_reset();
                cyc(1, 0, 0, 0, 16'h0);
                release_rst();
            end else begin
                ce = ($urandom_range(0, 3) == 0);
                ld = ($urandom_range(0, 39) == 0);
                st = ($urandom_range(0, 7) == 0);
                sp = ($urandom_range(0, 15) == 0);
                p  = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                 : {12'h0, 4'($urandom_range(0, 4))};
                cyc(ce, ld, st, sp, p);
            end
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
